// File: rtl/micro_irq_pkg.sv
// micro_irq_pkg: register offsets, read-FSM states and the ID encoder shared by micro_irq_ctrl.
// Timer offsets are only decoded when MICRO_IRQ_TIMER_EN is defined.
package micro_irq_pkg;

    localparam logic [3:0] IRQ_PEND    = 4'd0;
    localparam logic [3:0] IRQ_ENABLE  = 4'd1;
    localparam logic [3:0] IRQ_MODE    = 4'd2;
    localparam logic [3:0] IRQ_ACTIVE  = 4'd3;
    localparam logic [3:0] IRQ_ID      = 4'd4;
    localparam logic [3:0] IRQ_SET     = 4'd5;
    localparam logic [3:0] IRQ_TRELOAD = 4'd6;
    localparam logic [3:0] IRQ_TCOUNT  = 4'd7;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } rd_state_e;

    // Index+1 of the lowest set bit; 0 means nothing is set.
    function automatic logic [5:0] lowest_set_id(input logic [31:0] vec);
        logic [5:0] id;
        id = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) id = 6'(i + 1);
        end
        return id;
    endfunction

endpackage

// File: rtl/micro_irq_timer.sv
// micro_irq_timer: 16-bit periodic down-counter feeding pending bit 0.
// Only instantiated when MICRO_IRQ_TIMER_EN is defined; a zero reload value stops it.
module micro_irq_timer (
    input  logic        clock,
    input  logic        clock_sreset_n,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic        tick_o,
    output logic [15:0] treload_o,
    output logic [15:0] tcount_o
);

    logic [15:0] treload_q, treload_d;
    logic [15:0] tcount_q, tcount_d;
    logic        running;

    always_comb begin
        running   = (treload_q != 16'd0);
        tick_o    = running && (tcount_q == 16'd1);
        treload_d = treload_q;
        tcount_d  = tcount_q;
        if (load_i) begin
            treload_d = load_val_i;
            tcount_d  = load_val_i;
        end else if (tick_o) begin
            tcount_d = treload_q;
        end else if (running && (tcount_q != 16'd0)) begin
            tcount_d = tcount_q - 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            treload_q <= 16'd0;
            tcount_q  <= 16'd0;
        end else begin
            treload_q <= treload_d;
            tcount_q  <= tcount_d;
        end
    end

    assign treload_o = treload_q;
    assign tcount_o  = tcount_q;

endmodule

// File: rtl/micro_irq_ctrl.sv
// micro_irq_ctrl: memory-mapped level/edge interrupt controller on the forth_micro data bus.
// Define MICRO_IRQ_TIMER_EN to add the periodic timer that sources pending bit 0.
module micro_irq_ctrl
    import micro_irq_pkg::*;
#(
    parameter int                WIDTHA    = 16,
    parameter int                WIDTHD    = 18,
    parameter int                NSRC      = 16,
    parameter logic [WIDTHA-1:0] BASE_ADDR = 'h1f0
) (
    input  logic              clock,
    input  logic              clock_sreset_n,
    input  logic [WIDTHA-1:0] address,
    input  logic [WIDTHD-1:0] writedata,
    input  logic              read,
    input  logic              write,
    output logic [WIDTHD-1:0] readdata,
    output logic              waitrequest,
    input  logic [NSRC-1:0]   src,
    output logic [WIDTHD-1:0] irq,
    output logic              dbg_rd_wait_o
);

    logic              sel, rd_req, wr_en, rd_latch, tick;
    logic [3:0]        offset;
    logic [NSRC-1:0]   wd_src, set_term, clr_mask, active;
    logic [NSRC-1:0]   pend_q, pend_d, enable_q, enable_d, mode_q, mode_d, src_prev_q;
    logic [WIDTHD-1:0] readdata_q, readdata_d, irq_q, rd_val;
    rd_state_e         state_q, state_d;
    logic              unused_wdata;

    assign offset       = address[3:0];
    assign sel          = (address[WIDTHA-1:4] == BASE_ADDR[WIDTHA-1:4]);
    assign rd_req       = sel && read;
    assign wr_en        = sel && write && !read;
    assign wd_src       = writedata[NSRC-1:0];
    assign active       = pend_q & enable_q;
    assign unused_wdata = ^writedata;

`ifdef MICRO_IRQ_TIMER_EN
    logic [15:0] treload, tcount;

    micro_irq_timer u_timer (
        .clock          (clock),
        .clock_sreset_n (clock_sreset_n),
        .load_i         (wr_en && (offset == IRQ_TRELOAD)),
        .load_val_i     (writedata[15:0]),
        .tick_o         (tick),
        .treload_o      (treload),
        .tcount_o       (tcount)
    );
`else
    assign tick = 1'b0;
`endif

    // Read handshake: a selected read stalls one cycle (waitrequest high in IDLE) while
    // readdata is captured; the master sees waitrequest low in WAIT with readdata valid.
    always_comb begin
        state_d     = state_q;
        waitrequest = 1'b0;
        rd_latch    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clock_sreset_n && rd_req) begin
                    waitrequest = 1'b1;
                    rd_latch    = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            IRQ_PEND:    rd_val = WIDTHD'(pend_q);
            IRQ_ENABLE:  rd_val = WIDTHD'(enable_q);
            IRQ_MODE:    rd_val = WIDTHD'(mode_q);
            IRQ_ACTIVE:  rd_val = WIDTHD'(active);
            IRQ_ID:      rd_val = WIDTHD'(lowest_set_id(32'(active)));
`ifdef MICRO_IRQ_TIMER_EN
            IRQ_TRELOAD: rd_val = WIDTHD'(treload);
            IRQ_TCOUNT:  rd_val = WIDTHD'(tcount);
`endif
            default:     rd_val = '0;
        endcase
    end

    // Set beats clear on the same bit, so a level source held high re-pends immediately.
    always_comb begin
        set_term = (mode_q & src & ~src_prev_q) | (~mode_q & src) | NSRC'(tick);
        if (wr_en && (offset == IRQ_SET)) set_term = set_term | wd_src;
        clr_mask   = (wr_en && (offset == IRQ_PEND)) ? wd_src : '0;
        pend_d     = (pend_q & ~clr_mask) | set_term;
        enable_d   = (wr_en && (offset == IRQ_ENABLE)) ? wd_src : enable_q;
        mode_d     = (wr_en && (offset == IRQ_MODE)) ? wd_src : mode_q;
        readdata_d = rd_latch ? rd_val : readdata_q;
    end

    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            src_prev_q <= '0;
            readdata_q <= '0;
            irq_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            src_prev_q <= src;
            readdata_q <= readdata_d;
            irq_q      <= WIDTHD'(active);
        end
    end

    assign readdata      = readdata_q;
    assign irq           = irq_q;
    assign dbg_rd_wait_o = (state_q == WAIT);

endmodule

// File: tb/tb_micro_irq_ctrl.sv
// tb_micro_irq_ctrl: directed bench for micro_irq_ctrl with a per-cycle register-level model.
// Covers the timer when MICRO_IRQ_TIMER_EN is defined, reserved offsets 6/7 otherwise.
module tb_micro_irq_ctrl;

    localparam logic [15:0] BASE = 16'h01f0;
    localparam int          NS   = 16;

    logic        clock = 1'b0;
    logic        clock_sreset_n = 1'b0;
    logic [15:0] address = '0;
    logic [17:0] writedata = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [17:0] readdata;
    logic        waitrequest;
    logic [15:0] src = '0;
    logic [17:0] irq;
    logic        dbg_rd_wait_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    micro_irq_ctrl dut (
        .clock          (clock),
        .clock_sreset_n (clock_sreset_n),
        .address        (address),
        .writedata      (writedata),
        .read           (read),
        .write          (write),
        .readdata       (readdata),
        .waitrequest    (waitrequest),
        .src            (src),
        .irq            (irq),
        .dbg_rd_wait_o  (dbg_rd_wait_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_pend = '0, m_en = '0, m_mode = '0, m_srcd = '0;
    logic [15:0] m_trl = '0, m_tcnt = '0;
    logic [17:0] m_irq = '0, m_rd = '0;
    bit          m_wait = 0, chk_en = 0;
    logic        m_sel, m_wr, m_tick;
    logic [3:0]  m_off;
    logic [15:0] m_set, m_clr, m_wd;

    function automatic logic [17:0] m_read(input logic [3:0] off);
        logic [15:0] act;
        act = m_pend & m_en;
        case (off)
            4'd0: return {2'b00, m_pend};
            4'd1: return {2'b00, m_en};
            4'd2: return {2'b00, m_mode};
            4'd3: return {2'b00, act};
            4'd4: begin
                for (int i = 0; i < NS; i++) if (act[i]) return 18'(i + 1);
                return 18'd0;
            end
`ifdef MICRO_IRQ_TIMER_EN
            4'd6: return {2'b00, m_trl};
            4'd7: return {2'b00, m_tcnt};
`endif
            default: return 18'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
        if (!clock_sreset_n) begin
            m_pend = '0; m_en = '0; m_mode = '0; m_srcd = '0;
            m_trl = '0; m_tcnt = '0; m_irq = '0; m_rd = '0; m_wait = 0;
            chk_en = 1;
        end else begin
            m_sel = (address[15:4] == BASE[15:4]);
            m_off = address[3:0];
            m_wd  = writedata[15:0];
            m_wr  = m_sel && write && !read;
            if (!m_wait && m_sel && read) begin
                m_rd   = m_read(m_off);
                m_wait = 1;
            end else begin
                m_wait = 0;
            end
            m_tick = 1'b0;
`ifdef MICRO_IRQ_TIMER_EN
            m_tick = (m_trl != 0) && (m_tcnt == 16'd1);
`endif
            m_set = '0;
            for (int i = 0; i < NS; i++)
                if (m_mode[i] ? (src[i] && !m_srcd[i]) : src[i]) m_set[i] = 1'b1;
            if (m_wr && m_off == 4'd5) m_set = m_set | m_wd;
            if (m_tick) m_set[0] = 1'b1;
            m_clr = (m_wr && m_off == 4'd0) ? m_wd : 16'd0;
            m_irq = {2'b00, m_pend & m_en};
            m_pend = (m_pend & ~m_clr) | m_set;
            if (m_wr && m_off == 4'd1) m_en = m_wd;
            if (m_wr && m_off == 4'd2) m_mode = m_wd;
`ifdef MICRO_IRQ_TIMER_EN
            if (m_wr && m_off == 4'd6) begin
                m_trl = m_wd; m_tcnt = m_wd;
            end else if (m_tick) begin
                m_tcnt = m_trl;
            end else if (m_trl != 0) begin
                m_tcnt = m_tcnt - 16'd1;
            end
`endif
            m_srcd = src;
        end
    end

    // Compare process: every cycle after the first reset edge.
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            check("irq", irq, m_irq);
            check("readdata", readdata, m_rd);
            check("waitrequest", waitrequest,
                  clock_sreset_n && (address[15:4] == BASE[15:4]) && read && !m_wait);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [15:0] a, input logic [17:0] d);
        @(posedge clock); #1;
        address = a; writedata = d; write = 1'b1;
        @(posedge clock); #1;
        write = 1'b0;
    endtask

    task automatic wr_src(input logic [15:0] a, input logic [17:0] d, input logic [15:0] s);
        @(posedge clock); #1;
        address = a; writedata = d; write = 1'b1; src = s;
        @(posedge clock); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input bit also_wr, input logic [17:0] wdv,
                      output logic [17:0] d, output int waits);
        @(posedge clock); #1;
        address = a; read = 1'b1; write = also_wr; writedata = wdv; waits = 0;
        @(negedge clock);
        while (waitrequest === 1'b1 && waits < 8) begin
            waits++;
            @(negedge clock);
        end
        if (waits >= 8) begin
            total++; bad++;
            $display("FAIL rd_timeout: waitrequest still high after %0d cycles, need low", waits);
        end
        d = readdata;
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic rd_exp(input string name, input logic [15:0] a, input logic [17:0] exp);
        logic [17:0] d;
        int w;
        rd(a, 1'b0, 18'd0, d, w);
        check(name, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_irq0(input logic lvl, output int t);
        int n;
        n = 0;
        @(negedge clock);
        while (irq[0] !== lvl && n < 40) begin
            n++;
            @(negedge clock);
        end
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL timer_wait: irq[0]=%b, need %b within 40 cycles", irq[0], lvl);
        end
        t = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [17:0] d;
        int w, t1, t2, tx;

        clock_sreset_n = 1'b0;
        idle(3);
        @(negedge clock);
        check("rst_irq", irq, 0);
        check("rst_readdata", readdata, 0);
        check("rst_waitrequest", waitrequest, 0);
        @(posedge clock); #1;
        clock_sreset_n = 1'b1;

        rd(16'h01f1, 1'b0, 18'd0, d, w);
        check("enable_after_rst", d, 0);
        check("rd_wait_cycles", w, 1);

        // level source
        wr(16'h01f2, 18'h0);
        wr(16'h01f1, 18'h4);
        @(posedge clock); #1;
        src = 16'h0004;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("level_irq", irq, 18'h4);
        wr(16'h01f0, 18'h4);
        idle(2);
        @(negedge clock);
        check("level_repend", irq, 18'h4);
        @(posedge clock); #1;
        src = 16'h0000;
        wr(16'h01f0, 18'h4);
        @(negedge clock);
        check("clear_irq_1cyc", irq, 18'h4);
        @(negedge clock);
        check("clear_irq_2cyc", irq, 18'h0);

        // edge source
        wr(16'h01f2, 18'h8);
        wr(16'h01f1, 18'h8);
        @(posedge clock); #1;
        src = 16'h0008;
        idle(5);
        rd_exp("edge_pend_once", 16'h01f0, 18'h8);
        wr(16'h01f0, 18'h8);
        idle(3);
        rd_exp("edge_no_repend", 16'h01f0, 18'h0);
        src = 16'h0000;

        // SET, ACTIVE, ID
        wr(16'h01f5, 18'h30);
        wr(16'h01f1, 18'h20);
        rd_exp("set_pend", 16'h01f0, 18'h30);
        rd_exp("active", 16'h01f3, 18'h20);
        rd_exp("id_6", 16'h01f4, 18'd6);
        rd_exp("set_reads_0", 16'h01f5, 18'h0);
        wr(16'h01f1, 18'h30);
        rd_exp("id_5", 16'h01f4, 18'd5);
        wr(16'h01f1, 18'h0);
        rd_exp("id_none", 16'h01f4, 18'd0);

        // same-cycle set sources and set/clear conflict
        wr(16'h01f0, 18'hffff);
        wr(16'h01f2, 18'h2);
        wr_src(16'h01f5, 18'h1, 16'h0002);
        rd_exp("set_and_edge", 16'h01f0, 18'h3);
        src = 16'h0000;
        wr(16'h01f0, 18'hffff);
        wr_src(16'h01f0, 18'h2, 16'h0002);
        rd_exp("set_beats_clear", 16'h01f0, 18'h2);
        src = 16'h0000;

        // read+write together, reserved and unselected accesses
        wr(16'h01f1, 18'h5);
        rd(16'h01f1, 1'b1, 18'hffff, d, w);
        check("rw_read", d, 18'h5);
        rd_exp("rw_write_ignored", 16'h01f1, 18'h5);
        wr(16'h01f9, 18'h3ffff);
        rd_exp("reserved_9", 16'h01f9, 18'h0);
        wr(16'h00f1, 18'h7);
        rd_exp("unsel_write", 16'h01f1, 18'h5);
        rd(16'h02f1, 1'b0, 18'd0, d, w);
        check("unsel_nowait", w, 0);

`ifdef MICRO_IRQ_TIMER_EN
        wr(16'h01f2, 18'h0);
        wr(16'h01f0, 18'hffff);
        wr(16'h01f1, 18'h1);
        wr(16'h01f6, 18'd10);
        rd_exp("treload", 16'h01f6, 18'd10);
        wait_irq0(1'b1, t1);
        wr(16'h01f0, 18'h1);
        wait_irq0(1'b0, tx);
        wait_irq0(1'b1, t2);
        check("timer_period", t2 - t1, 10);
        wr(16'h01f6, 18'd0);
        wr(16'h01f0, 18'h1);
        idle(30);
        @(negedge clock);
        check("timer_stopped", irq[0], 0);
        rd_exp("tcount_stopped", 16'h01f7, 18'd0);
`else
        wr(16'h01f6, 18'h5);
        wr(16'h01f7, 18'h5);
        rd_exp("off6_reserved", 16'h01f6, 18'h0);
        rd_exp("off7_reserved", 16'h01f7, 18'h0);
`endif

        // reset in the middle of a read
        wr(16'h01f2, 18'h4);
        wr(16'h01f5, 18'h1);
        @(posedge clock); #1;
        address = 16'h01f1; read = 1'b1;
        @(posedge clock); #1;
        clock_sreset_n = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_midread_wait", waitrequest, 0);
        @(posedge clock); #1;
        read = 1'b0;
        clock_sreset_n = 1'b1;
        for (int o = 0; o < 8; o++) begin
            rd(16'(BASE + 16'(o)), 1'b0, 18'd0, d, w);
            check("rst_regs_zero", d, 0);
        end
        @(negedge clock);
        check("rst_irq_zero", irq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
